// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The entry struct is shared by the top module and its result FIFO.
package rf_writeback_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYPASS
    } src_sel_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular FIFO holding long-latency results until the write port is free.
// Push and pop may happen in the same cycle; a push is ignored when full unless a pop frees a slot.
module rf_wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage is data-only; its contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Write-side master for the register file: merges never-stalled ALU results with
// buffered long-latency results and tracks destinations with outstanding long-latency writes.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_arstn,
    input  logic              alu_wen,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [AW-1:0]     lu_rd,
    input  logic [XLEN-1:0]   lu_wdata,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREG-1:0]   pending,
    output logic              RegWrite,
    output logic [AW-1:0]     w_addr,
    output logic [XLEN-1:0]   w_data
);

    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t        fifo_head;
    wb_entry_t        sel_entry;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             lu_fire;
    logic             lu_keep;
    src_sel_e         src;
    logic [NREG-1:0]  pending_next;

    // lu_ready depends only on FIFO occupancy so producers see no path from lu_valid.
    assign lu_ready = (fifo_count < CW'(DEPTH));
    assign lu_fire  = lu_valid && !fifo_full;
    assign lu_keep  = lu_fire && (lu_rd != '0);

    always_comb begin
        src       = SRC_NONE;
        sel_entry = '{rd: '0, data: '0};
        if (alu_wen && (alu_rd != '0)) begin
            src       = SRC_ALU;
            sel_entry = '{rd: alu_rd, data: alu_wdata};
        end else if (!fifo_empty) begin
            src       = SRC_FIFO;
            sel_entry = fifo_head;
        end else if (lu_keep) begin
            src       = SRC_BYPASS;
            sel_entry = '{rd: lu_rd, data: lu_wdata};
        end
    end

    assign fifo_push = lu_keep && (src != SRC_BYPASS);
    assign fifo_pop  = (src == SRC_FIFO);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (sys_clk),
        .rst_n      (sys_arstn),
        .push       (fifo_push),
        .push_entry ('{rd: lu_rd, data: lu_wdata}),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A new issue to the same register outranks the retirement seen this cycle.
    always_comb begin
        pending_next = pending;
        if ((src == SRC_FIFO) || (src == SRC_BYPASS)) pending_next[sel_entry.rd] = 1'b0;
        if (iss_valid && (iss_rd != '0))               pending_next[iss_rd]       = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            pending  <= '0;
            RegWrite <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            pending  <= pending_next;
            RegWrite <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                w_addr <= sel_entry.rd;
                w_data <= sel_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the write-back rules.
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        sys_clk = 1'b0;
    logic        sys_arstn;
    logic        alu_wen;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] pending;
    logic        RegWrite;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] m_q [$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ready;
    logic        obs_ready;
    logic [31:0] wr_log [$];

    rf_writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_arstn (sys_arstn),
        .alu_wen   (alu_wen),
        .alu_rd    (alu_rd),
        .alu_wdata (alu_wdata),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_rd     (lu_rd),
        .lu_wdata  (lu_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .pending   (pending),
        .RegWrite  (RegWrite),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_clear();
        m_q.delete();
        m_pend = '0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Drives one cycle of inputs, advances the reference model, and returns at posedge+1.
    task automatic cycle(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ird);
        logic [36:0] e;
        logic        fire;
        logic        byp;
        alu_wen = aw; alu_rd = ard; alu_wdata = ad;
        lu_valid = lv; lu_rd = lrd; lu_wdata = ld;
        iss_valid = iv; iss_rd = ird;
        obs_ready = lu_ready;
        m_ready   = (m_q.size() < DEPTH);
        fire = lv && m_ready;
        byp  = 1'b0;
        if (aw && ard != 0) begin
            m_we = 1'b1; m_addr = ard; m_data = ad;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
            m_pend[e[36:32]] = 1'b0;
        end else if (fire && lrd != 0) begin
            byp = 1'b1;
            m_we = 1'b1; m_addr = lrd; m_data = ld;
            m_pend[lrd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (fire && lrd != 0 && !byp) m_q.push_back({lrd, ld});
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        @(posedge sys_clk);
        #1;
        if (RegWrite) wr_log.push_back(w_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        n_checks++;
        if (RegWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regwrite: got %b expected 0", RegWrite); end
        n_checks++;
        if (w_addr !== 5'd0 || w_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_wport: got addr=%0d data=%h expected 0/0", w_addr, w_data); end
        n_checks++;
        if (pending !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pending: got %h expected 0", pending); end
        n_checks++;
        if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", lu_ready); end
    endtask

    task automatic test_bypass();
        wr_log.delete();
        cycle(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
        n_checks++;
        if (RegWrite !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEADBEEF) begin
            n_fail++; $display("[TB] FAIL bypass_write: got we=%b addr=%0d data=%h expected 1/5/deadbeef", RegWrite, w_addr, w_data);
        end
        idle(1);
        n_checks++;
        if (RegWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_fifo_empty: got we=%b expected 0", RegWrite); end
    endtask

    task automatic test_preempt_order();
        logic [31:0] exp_seq [5] = '{32'h11, 32'h22, 32'h33, 32'hA0, 32'hB0};
        wr_log.delete();
        cycle(1, 5'd1, 32'h11, 1, 5'd7, 32'hA0, 0, 0);
        cycle(1, 5'd1, 32'h22, 1, 5'd8, 32'hB0, 0, 0);
        n_checks++;
        if (lu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL preempt_ready_full: got %b expected 0", lu_ready); end
        cycle(1, 5'd1, 32'h33, 0, 0, 0, 0, 0);
        idle(3);
        n_checks++;
        if (wr_log.size() != 5) begin
            n_fail++; $display("[TB] FAIL preempt_count: got %0d writes expected 5", wr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr_log[i] !== exp_seq[i]) begin n_fail++; $display("[TB] FAIL preempt_order[%0d]: got %h expected %h", i, wr_log[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_full_stall();
        logic [4:0]  it_rd [3] = '{5'd10, 5'd11, 5'd12};
        logic [31:0] it_d  [3] = '{32'hC1, 32'hC2, 32'hC3};
        int idx = 0;
        int acc_busy = 0;
        logic rdy;
        wr_log.delete();
        for (int c = 0; c < 12; c++) begin
            rdy = lu_ready;
            cycle(c < 4, 5'd2, 32'(c), idx < 3, it_rd[idx < 3 ? idx : 0], it_d[idx < 3 ? idx : 0], 0, 0);
            if (idx < 3 && rdy) begin
                if (c < 4) acc_busy++;
                idx++;
            end
        end
        n_checks++;
        if (acc_busy != 2) begin n_fail++; $display("[TB] FAIL stall_accepted: got %0d expected 2", acc_busy); end
        n_checks++;
        if (idx != 3) begin n_fail++; $display("[TB] FAIL stall_third_accepted: got %0d accepted expected 3", idx); end
        n_checks++;
        if (wr_log.size() != 7 || wr_log[4] !== 32'hC1 || wr_log[5] !== 32'hC2 || wr_log[6] !== 32'hC3) begin
            n_fail++; $display("[TB] FAIL stall_order: got %0d writes, tail %h expected 7 writes ending c1,c2,c3",
                               wr_log.size(), wr_log.size() > 0 ? wr_log[wr_log.size()-1] : 32'hx);
        end
    endtask

    task automatic test_x0();
        cycle(1, 5'd1, 32'h1, 1, 5'd3, 32'h55, 0, 0);
        cycle(1, 5'd0, 32'hAA, 0, 0, 0, 0, 0);
        n_checks++;
        if (RegWrite !== 1'b1 || w_addr !== 5'd3 || w_data !== 32'h55) begin
            n_fail++; $display("[TB] FAIL x0_alu_skip: got we=%b addr=%0d data=%h expected 1/3/55", RegWrite, w_addr, w_data);
        end
        cycle(1, 5'd1, 32'h2, 1, 5'd0, 32'h99, 0, 0);
        cycle(0, 0, 0, 1, 5'd0, 32'h98, 0, 0);
        n_checks++;
        if (RegWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_lu_drop: got we=%b addr=%0d expected no write", RegWrite, w_addr); end
        n_checks++;
        if (lu_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_count_unchanged: got ready=%b expected 1", lu_ready); end
    endtask

    task automatic test_scoreboard();
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
        n_checks++;
        if (pending[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_set: got %b expected 1", pending[9]); end
        cycle(1, 5'd9, 32'h909, 0, 0, 0, 0, 0);
        n_checks++;
        if (pending[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_alu_no_clear: got %b expected 1", pending[9]); end
        cycle(0, 0, 0, 1, 5'd9, 32'h9A, 0, 0);
        n_checks++;
        if (pending[9] !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_clear: got %b expected 0", pending[9]); end
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9);
        cycle(0, 0, 0, 1, 5'd9, 32'h9B, 1, 5'd9);
        n_checks++;
        if (pending[9] !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_set_wins: got %b expected 1", pending[9]); end
        cycle(0, 0, 0, 1, 5'd9, 32'h9C, 1, 5'd0);
        n_checks++;
        if (pending !== 32'd0) begin n_fail++; $display("[TB] FAIL sb_final: got %h expected 0", pending); end
    endtask

    task automatic test_reset_midstream();
        cycle(1, 5'd1, 32'h1, 1, 5'd20, 32'hE1, 1, 5'd4);
        cycle(1, 5'd1, 32'h2, 1, 5'd21, 32'hE2, 0, 0);
        alu_wen = 0; lu_valid = 0; iss_valid = 0;
        sys_arstn = 1'b0;
        #2;
        test_reset();
        @(posedge sys_clk);
        #1;
        sys_arstn = 1'b1;
        model_clear();
        wr_log.delete();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (RegWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_discard[%0d]: got we=%b data=%h expected no write", i, RegWrite, w_data); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
            n_checks++;
            if (obs_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, obs_ready, m_ready); end
            n_checks++;
            if (RegWrite !== m_we || w_addr !== m_addr || w_data !== m_data) begin
                n_fail++; $display("[TB] FAIL rnd_write[%0d]: got %b/%0d/%h expected %b/%0d/%h", i, RegWrite, w_addr, w_data, m_we, m_addr, m_data);
            end
            n_checks++;
            if (pending !== m_pend) begin n_fail++; $display("[TB] FAIL rnd_pending[%0d]: got %h expected %h", i, pending, m_pend); end
        end
    endtask

    initial begin
        sys_arstn = 1'b0;
        alu_wen = 0; alu_rd = 0; alu_wdata = 0;
        lu_valid = 0; lu_rd = 0; lu_wdata = 0;
        iss_valid = 0; iss_rd = 0;
        model_clear();
        #12;
        test_reset();
        @(posedge sys_clk);
        #1;
        sys_arstn = 1'b1;
        test_bypass();
        test_preempt_order();
        test_full_stall();
        idle(3);
        test_x0();
        idle(3);
        test_scoreboard();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side master for the 32x32 register file's single write port; drives RegWrite, w_addr and w_data.
- Merges two result sources:
  - single-cycle ALU results, which are never stalled;
  - long-latency results (load/MDU), which use a valid/ready handshake.
- Long-latency results are buffered in a small FIFO until the write port is free.
- Keeps a pending-destination scoreboard so issue/hazard logic can stall on registers with outstanding long-latency writes.

Parameters:
- XLEN, 32, data width of register writes.
- AW, 5, register address width; 2**AW registers.
- DEPTH, 2, long-latency result FIFO entries; must be >= 1.

Ports:
- sys_clk  in  1  clock; all state on rising edge.
- sys_arstn  in  1  asynchronous active-low reset.
- alu_wen  in  1  ALU result valid this cycle; always accepted.
- alu_rd  in  AW  ALU destination register.
- alu_wdata  in  XLEN  ALU result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  arbiter can accept a long-latency result.
- lu_rd  in  AW  long-latency destination register.
- lu_wdata  in  XLEN  long-latency result.
- iss_valid  in  1  a long-latency op issued this cycle.
- iss_rd  in  AW  destination of the issued op.
- pending  out  2**AW  bit r=1: register r awaits a long-latency write.
- RegWrite  out  1  register file write enable (registered).
- w_addr  out  AW  write address (registered).
- w_data  out  XLEN  write data (registered).

Behaviour:
- Reset (async, sys_arstn=0): FIFO empty (count=0, pointers 0); pending=0; RegWrite=0; w_addr=0; w_data=0.
  - Reset mid-operation discards all buffered results and pending bits.
  - lu_ready reads 1 during reset. Producers must hold lu_valid=0 while in reset.
- Long-latency handshake:
  - lu_ready = (count < DEPTH), purely from state, with no combinational path from lu_valid.
  - A transfer occurs when lu_valid && lu_ready.
  - A transfer with lu_rd==0 is accepted and dropped: no enqueue, no write.
- Write source selection, evaluated each cycle, first match wins:
  1. alu_wen && alu_rd!=0 -> ALU.
  2. count>0 -> FIFO head (pop).
  3. count==0 and a lu transfer with lu_rd!=0 -> bypass; the transfer is not enqueued.
  4. Otherwise no write.
- A non-bypassed lu transfer is enqueued at the tail in the same cycle. Push and pop can occur in the same cycle, and count is unchanged.
- Output latency: the selected {1, rd, data} is registered onto RegWrite/w_addr/w_data at the next rising edge, so the write lands one cycle later. With no selection, RegWrite<=0 and w_addr/w_data hold their values.
- Never emits RegWrite=1 with w_addr=0. Exactly one write per cycle at most.
- Ordering: long-latency results retire in arrival order. The ALU always preempts them.
- Starvation: continuous ALU writes fill the FIFO, lu_ready then goes 0, and producers stall. This is the accepted behaviour; there is no aging.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Scoreboard (pending):
  - Set bit iss_rd on iss_valid && iss_rd!=0.
  - Clear bit r when a long-latency result (FIFO or bypass) is selected for rd=r, in the cycle of selection.
  - Set and clear of the same bit in the same cycle: set wins.
  - pending[0] is constant 0.
  - ALU writes never clear pending bits. WAW avoidance is the job of upstream hazard logic.

Decomposition:
- Shared package:
  - XLEN and AW constants;
  - a wb_entry_t struct {rd[AW-1:0], data[XLEN-1:0]};
  - source-select enum {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYPASS}.
- One sub-module: rf_wb_fifo (parameterised DEPTH, wb_entry_t entries, push/pop/count/full/empty).
- Arbitration, scoreboard and output registers live in the top module.

Test Plan:
- Reset: assert sys_arstn=0 mid-stream with 2 FIFO entries -> RegWrite=0, w_addr=0, w_data=0, pending=0, lu_ready=1. After release, no write of the buffered data ever appears.
- Bypass: FIFO empty, alu_wen=0, lu transfer rd=5 data=0xDEADBEEF -> next cycle RegWrite=1, w_addr=5, w_data=0xDEADBEEF; FIFO stays empty.
- Preempt/ordering: alu_wen=1 for 3 cycles (rd=1, data 0x11/0x22/0x33) while lu sends rd=7 0xA0 then rd=8 0xB0:
  - writes appear in order 0x11, 0x22, 0x33, 0xA0, 0xB0;
  - lu_ready=0 once count=2.
- Full/stall: DEPTH=2, ALU busy continuously, 3 lu_valid attempts -> only 2 accepted; the 3rd is held until the first drain cycle, then written last.
- x0 handling:
  - alu_wen=1 with alu_rd=0, FIFO holding rd=3 0x55 -> FIFO entry written (w_addr=3).
  - lu transfer rd=0 -> accepted, no write, count unchanged.
- Scoreboard:
  - iss_valid rd=9 -> pending[9]=1 next cycle; stays set across an ALU write to 9; clears when the lu result for rd=9 is selected.
  - iss_valid rd=9 in the same cycle that the rd=9 result is selected -> pending[9] stays 1.
